// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the two-owner RAM port arbiter: FSM state encoding,
// owner encoding and the default RAM geometry.
package proc_pkg;

    // Default RAM geometry: 128 words of 16 bits.
    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 16;

    // Arbiter ownership state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_P = 2'd1,
        OWN_H = 2'd2
    } arb_state_t;

    // Who holds (or last held) the RAM port.
    typedef enum logic {
        OWN_PROC = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // The requester that is not 'o'; used for round-robin on contention.
    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_PROC) ? OWN_HOST : OWN_PROC;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of processor, host and RAM-side signals around the arbiter.
//
// Handshake: a requester holds *_req (with *_we/*_addr/*_wdata stable) and
// the access is taken in every cycle where *_gnt is 1 in that same cycle.
// A granted read returns *_rvalid=1 with *_rdata exactly one cycle later;
// there is no back-pressure on read data.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = proc_pkg::ADDR_W_DEF,
    parameter int DATA_W = proc_pkg::DATA_W_DEF
);
    import proc_pkg::*;

    // Processor port
    logic              p_req;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_gnt;
    logic              p_rvalid;
    logic [DATA_W-1:0] p_rdata;

    // Host (loader/dump) port
    logic              h_req;
    logic              h_we;
    logic              h_lock;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_gnt;
    logic              h_rvalid;
    logic [DATA_W-1:0] h_rdata;

    // RAM side
    logic              ram_read_en;
    logic              ram_write_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    // Observation of the arbiter FSM
    arb_state_t        dbg_state;

    // Arbiter view
    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_gnt, p_rvalid, p_rdata,
        input  h_req, h_we, h_lock, h_addr, h_wdata,
        output h_gnt, h_rvalid, h_rdata,
        output ram_read_en, ram_write_en, ram_addr, ram_din,
        input  ram_dout,
        output dbg_state
    );

    // Environment view (requesters plus RAM)
    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_gnt, p_rvalid, p_rdata,
        output h_req, h_we, h_lock, h_addr, h_wdata,
        input  h_gnt, h_rvalid, h_rdata,
        input  ram_read_en, ram_write_en, ram_addr, ram_din,
        output ram_dout,
        input  dbg_state
    );

endinterface

// File: rtl/ram_port_arbiter.sv
// Arbitrates one single-port RAM between a processor and a host port.
// Grants are combinational in the request cycle; ownership is held while the
// owner keeps requesting, bounded by MAX_HOLD grants when the other side
// waits, unless the host holds h_lock. Read data returns one cycle later and
// is steered to the owner recorded in a one-entry read tag.
module ram_port_arbiter
    import proc_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_port_arbiter_if.slave  bus
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    // Registered arbiter state
    arb_state_t       state_q,      state_d;
    owner_t           last_owner_q, last_owner_d;
    logic [CNT_W-1:0] hold_cnt_q,   hold_cnt_d;
    logic             tag_valid_q,  tag_valid_d;
    owner_t           tag_owner_q,  tag_owner_d;

    // Combinational grant decision
    logic              grant_any;
    owner_t            winner;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              gnt_live;

    // Count a grant, sticking at the limit so a long locked burst still
    // triggers a hand-over as soon as the lock is released.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == HOLD_LAST) ? v : v + CNT_W'(1);
    endfunction

    // Next ownership, hold count and grant for the current cycle
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        grant_any    = 1'b0;
        winner       = OWN_PROC;
        case (state_q)
            IDLE: begin
                if (bus.p_req || bus.h_req) begin
                    grant_any = 1'b1;
                    if (bus.p_req && bus.h_req) begin
                        winner = other_owner(last_owner_q);
                    end else if (bus.h_req) begin
                        winner = OWN_HOST;
                    end else begin
                        winner = OWN_PROC;
                    end
                    state_d      = (winner == OWN_HOST) ? OWN_H : OWN_P;
                    last_owner_d = winner;
                    // The IDLE grant is the first grant of the new tenure.
                    hold_cnt_d   = sat_inc('0);
                end
            end
            OWN_P: begin
                winner = OWN_PROC;
                if (!bus.p_req) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end else begin
                    grant_any = 1'b1;
                    if (hold_cnt_q == HOLD_LAST && bus.h_req) begin
                        state_d      = OWN_H;
                        last_owner_d = OWN_HOST;
                        hold_cnt_d   = '0;
                    end else begin
                        hold_cnt_d = sat_inc(hold_cnt_q);
                    end
                end
            end
            OWN_H: begin
                winner = OWN_HOST;
                if (bus.h_lock) begin
                    // Locked burst: no limit, and gaps in h_req keep ownership.
                    grant_any = bus.h_req;
                    if (bus.h_req) begin
                        hold_cnt_d = sat_inc(hold_cnt_q);
                    end
                end else if (!bus.h_req) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end else begin
                    grant_any = 1'b1;
                    if (hold_cnt_q == HOLD_LAST && bus.p_req) begin
                        state_d      = OWN_P;
                        last_owner_d = OWN_PROC;
                        hold_cnt_d   = '0;
                    end else begin
                        hold_cnt_d = sat_inc(hold_cnt_q);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Select the winner's request fields for the RAM
    always_comb begin
        win_we    = (winner == OWN_HOST) ? bus.h_we    : bus.p_we;
        win_addr  = (winner == OWN_HOST) ? bus.h_addr  : bus.p_addr;
        win_wdata = (winner == OWN_HOST) ? bus.h_wdata : bus.p_wdata;
    end

    // Read tag for the access issued this cycle
    always_comb begin
        tag_valid_d = grant_any & ~win_we;
        tag_owner_d = winner;
    end

    // State, ownership history, hold counter and read tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_HOST;
            hold_cnt_q   <= '0;
            tag_valid_q  <= 1'b0;
            tag_owner_q  <= OWN_PROC;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            tag_valid_q  <= tag_valid_d;
            tag_owner_q  <= tag_owner_d;
        end
    end

    // Grants are gated by rst_n so reset silences the RAM immediately.
    assign gnt_live = rst_n & grant_any;

    assign bus.p_gnt = gnt_live & (winner == OWN_PROC);
    assign bus.h_gnt = gnt_live & (winner == OWN_HOST);

    assign bus.ram_read_en  = gnt_live & ~win_we;
    assign bus.ram_write_en = gnt_live &  win_we;
    assign bus.ram_addr     = gnt_live ? win_addr  : '0;
    assign bus.ram_din      = gnt_live ? win_wdata : '0;

    // Read return steered to the tagged owner; the other side sees zeros.
    assign bus.p_rvalid = tag_valid_q & (tag_owner_q == OWN_PROC);
    assign bus.h_rvalid = tag_valid_q & (tag_owner_q == OWN_HOST);
    assign bus.p_rdata  = bus.p_rvalid ? bus.ram_dout : '0;
    assign bus.h_rdata  = bus.h_rvalid ? bus.ram_dout : '0;

    assign bus.dbg_state = state_q;

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, meaning RAM address width (128 words).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning RAM word width.
REQ-003 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive grants to one owner while the other owner is requesting.
REQ-004 Port clk, input, 1, meaning the single clock, with all logic on its rising edge.
REQ-005 Port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 Ports p_req, p_we, input, 1 each, meaning processor access request and write-not-read.
REQ-007 Ports p_addr (ADDR_W) and p_wdata (DATA_W), input, meaning processor address and write data.
REQ-008 Ports p_gnt, p_rvalid, output, 1 each, meaning the access is accepted this cycle and read data is valid.
REQ-009 Port p_rdata, output, DATA_W, meaning processor read data.
REQ-010 Ports h_req, h_we, h_lock, input, 1 each, meaning host (loader/dump) request, write-not-read, and burst lock.
REQ-011 Ports h_addr, h_wdata, input, and h_gnt, h_rvalid, h_rdata, output, meaning the host mirror of the processor ports.
REQ-012 Ports ram_read_en, ram_write_en, output, 1 each, meaning the RAM strobes.
REQ-013 Ports ram_addr (ADDR_W) and ram_din (DATA_W), output, meaning the RAM address and write data.
REQ-014 Port ram_dout, input, DATA_W, meaning RAM read data, registered with 1-cycle latency.

Function
REQ-015 FSM states: IDLE, OWN_P, OWN_H; the state SHALL be registered.
REQ-016 In IDLE, when only one requester is active, the FSM SHALL move to that requester's OWN state, granting in the same cycle (combinational grant).
REQ-017 In IDLE with both requesters active, the FSM SHALL grant the requester not recorded in last_owner; after reset the processor wins.
REQ-018 Grant is p_gnt = p_req in OWN_P, or p_req winning in IDLE; h_gnt is the same for the host. p_gnt and h_gnt SHALL never both be 1.
REQ-019 On a grant cycle, the RAM strobes SHALL be driven from the winner's request: ram_read_en = ~we, ram_write_en = we, and addr/din copied from the winner.
REQ-020 When there is no grant, ram_read_en and ram_write_en SHALL be 0 and ram_addr/ram_din SHALL hold 0.
REQ-021 A granted read SHALL register a 1-bit tag with its owner; in the next cycle the owner's rvalid SHALL be 1 and its rdata SHALL equal ram_dout.
REQ-022 Non-owner rdata SHALL be 0 and its rvalid SHALL be 0.
REQ-023 In OWN_x, hold_cnt SHALL increment on each grant; the count SHALL clear on an ownership change.
REQ-024 Ownership SHALL stay with the current owner while it requests.
REQ-025 Ownership SHALL return to IDLE when the owner drops its request.
REQ-026 Ownership SHALL switch to the other requester, without an idle cycle, when hold_cnt == MAX_HOLD-1 and the other is requesting.
REQ-027 While h_lock=1 in OWN_H, the hold limit SHALL be ignored.
REQ-028 While h_lock=1 in OWN_H and h_req drops, the FSM SHALL stay in OWN_H with no grant; it SHALL release only when h_lock=0.
REQ-029 last_owner SHALL update on every ownership change.
REQ-030 Writes SHALL produce no rvalid.
REQ-031 A read and a write in consecutive cycles by different owners SHALL both complete, with the rvalid tag unaffected by the write.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately force IDLE, last_owner=host, hold_cnt=0, tag valid=0, all gnt/rvalid/strobes=0, and all rdata=0.
REQ-033 Reset mid-read SHALL drop the pending rvalid and not replay it.

Structure
REQ-034 The FSM state encoding, the owner encoding (OWN_PROC=0, OWN_HOST=1), and the ADDR_W/DATA_W defaults SHALL reside in the shared package proc_pkg.
REQ-035 The design SHALL be one module with no sub-modules; the hold counter SHALL be $clog2(MAX_HOLD) bits wide.

Verification
REQ-036 p_req read addr 0x05 alone, RAM[5]=0x3c00 -> p_gnt in cycle 0, ram_read_en=1 with addr 0x05, p_rvalid=1 with p_rdata=0x3c00 in cycle 1.
REQ-037 Both requesters held high for 20 cycles after reset -> processor gets 8 grants, host gets 8, processor gets 4, with no gap cycle and never both gnt.
REQ-038 Host h_lock=1 writes addresses 0..15 while p_req=1 -> 16 consecutive h_gnt; p_gnt starts the cycle after h_lock falls.
REQ-039 Host read of addr 0x10, then processor write of addr 0x10 the next cycle -> h_rvalid only, with the old data, and p_rvalid stays 0.
REQ-040 rst_n pulsed low mid-read -> no rvalid in the following cycle; state returns to IDLE asynchronously.
